// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM bank port bundle between the application host and the on-chip memory responder.
// Latency: none, wires only.
// Backpressure: waitrequest from the responder; readdatavalid is never backpressured.
interface avalon_mem_responder_if #(
    parameter int ADDR_WIDTH  = 27,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7
);
    logic                      avs_read;
    logic                      avs_write;
    logic [ADDR_WIDTH-1:0]     avs_address;
    logic [BURST_WIDTH-1:0]    avs_burstcount;
    logic [DATA_WIDTH-1:0]     avs_writedata;
    logic [DATA_WIDTH/8-1:0]   avs_byteenable;
    logic                      avs_waitrequest;
    logic [DATA_WIDTH-1:0]     avs_readdata;
    logic                      avs_readdatavalid;

    modport master (
        output avs_read, avs_write, avs_address, avs_burstcount, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_read, avs_write, avs_address, avs_burstcount, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// Avalon-MM burst responder backed by on-chip RAM; optional random stalls under AVL_RESP_RANDOM_STALL_EN.
// Latency: first read beat READ_LATENCY+2 cycles after the accepting edge; writes commit on the accepting edge.
// Backpressure: waitrequest held during read issue; issue is credit-limited so the response FIFO never overflows.
module avalon_mem_responder #(
    parameter int ADDR_WIDTH     = 27,
    parameter int DATA_WIDTH     = 512,
    parameter int BURST_WIDTH    = 7,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 4,
    parameter int RSP_FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avalon_mem_responder_if.slave  avs,
    output logic [63:0]            rd_beats,
    output logic [63:0]            wr_beats,
    output logic                   err_sticky
);
    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;
    localparam int FIFO_AW   = $clog2(RSP_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE} state_t;

    state_t                      r_state, w_state_nxt;
    logic                        r_ready;
    logic [MEM_DEPTH_LOG2-1:0]   r_addr, w_addr_nxt, w_commit_addr;
    logic [BURST_WIDTH-1:0]      r_remaining, w_rem_nxt;
    logic                        w_wait, w_commit, w_issue, w_err, w_stall;
    logic                        r_err;
    logic [63:0]                 r_rd_beats, r_wr_beats;

    logic [DATA_WIDTH-1:0]       r_mem [MEM_WORDS];
    logic [READ_LATENCY-1:0]     r_pipe_vld;
    logic [DATA_WIDTH-1:0]       r_pipe_dat [READ_LATENCY];

    logic [DATA_WIDTH-1:0]       r_fifo [RSP_FIFO_DEPTH];
    logic [FIFO_AW:0]            r_wr_ptr, r_rd_ptr, w_fifo_cnt;
    logic                        w_push, w_pop, w_full, w_empty, w_credit_ok;
    logic [31:0]                 w_in_flight, w_used;

    logic                        r_rdv;
    logic [DATA_WIDTH-1:0]       r_rdata;

    // Address bits above the RAM index are intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^avs.avs_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];

`ifdef AVL_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;
    // Free-running LFSR; a 2'b00 in the low bits stalls accept, issue and pop together.
    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Credit counts FIFO occupancy plus every read still travelling down the RAM pipeline.
    assign w_fifo_cnt  = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_fifo_cnt == '0);
    assign w_full      = (32'(w_fifo_cnt) == RSP_FIFO_DEPTH);
    assign w_in_flight = $countones(r_pipe_vld);
    assign w_used      = 32'(w_fifo_cnt) + w_in_flight;
    assign w_credit_ok = (w_used < RSP_FIFO_DEPTH);
    assign w_push      = r_pipe_vld[READ_LATENCY-1];
    assign w_pop       = !w_empty && !w_stall;

    // State register plus the burst address/remaining trackers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= 1'b1;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_rem_nxt;
        end
    end

    // Next-state, accept/commit/issue decisions and protocol-error detection.
    always_comb begin
        w_state_nxt   = r_state;
        w_wait        = 1'b1;
        w_commit      = 1'b0;
        w_commit_addr = r_addr;
        w_issue       = 1'b0;
        w_err         = 1'b0;
        w_addr_nxt    = r_addr;
        w_rem_nxt     = r_remaining;
        case (r_state)
            IDLE: begin
                w_wait = !r_ready || w_stall;
                if (!w_wait && avs.avs_write) begin
                    if (avs.avs_read) w_err = 1'b1;
                    if (avs.avs_burstcount == '0) begin
                        w_err = 1'b1;
                    end else begin
                        w_commit      = 1'b1;
                        w_commit_addr = avs.avs_address[MEM_DEPTH_LOG2-1:0];
                        w_addr_nxt    = avs.avs_address[MEM_DEPTH_LOG2-1:0] + MEM_DEPTH_LOG2'(1);
                        w_rem_nxt     = avs.avs_burstcount - BURST_WIDTH'(1);
                        if (avs.avs_burstcount != BURST_WIDTH'(1)) w_state_nxt = WR_BURST;
                    end
                end else if (!w_wait && avs.avs_read) begin
                    if (avs.avs_burstcount == '0) begin
                        w_err = 1'b1;
                    end else begin
                        w_addr_nxt  = avs.avs_address[MEM_DEPTH_LOG2-1:0];
                        w_rem_nxt   = avs.avs_burstcount;
                        w_state_nxt = RD_ISSUE;
                    end
                end
            end
            WR_BURST: begin
                w_wait = w_stall;
                if (avs.avs_read) w_err = 1'b1;
                if (!w_wait && avs.avs_write) begin
                    w_commit   = 1'b1;
                    w_addr_nxt = r_addr + MEM_DEPTH_LOG2'(1);
                    w_rem_nxt  = r_remaining - BURST_WIDTH'(1);
                    if (r_remaining == BURST_WIDTH'(1)) w_state_nxt = IDLE;
                end
            end
            RD_ISSUE: begin
                if (w_credit_ok && !w_stall) begin
                    w_issue    = 1'b1;
                    w_addr_nxt = r_addr + MEM_DEPTH_LOG2'(1);
                    w_rem_nxt  = r_remaining - BURST_WIDTH'(1);
                    if (r_remaining == BURST_WIDTH'(1)) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // RAM write port with byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && rst_n) begin
            for (int b = 0; b < BE_W; b++) begin
                if (avs.avs_byteenable[b]) r_mem[w_commit_addr][b*8 +: 8] <= avs.avs_writedata[b*8 +: 8];
            end
        end
    end

    // Read pipeline valids; reset drops any reads still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
    end

    // Read pipeline data: RAM sampled every cycle, qualified by the valids.
    always_ff @(posedge clk) begin
        r_pipe_dat[0] <= r_mem[r_addr];
        for (int i = 1; i < READ_LATENCY; i++) r_pipe_dat[i] <= r_pipe_dat[i-1];
    end

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= r_pipe_dat[READ_LATENCY-1];
    end

    // Response FIFO pointers; the credit rule must keep pushes off a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            assert (!(w_push && w_full && !w_pop)) else $error("response FIFO overflow");
            if (w_push) r_wr_ptr <= r_wr_ptr + (FIFO_AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (FIFO_AW+1)'(1);
        end
    end

    // Registered read response, beat counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdv      <= 1'b0;
            r_rdata    <= '0;
            r_rd_beats <= '0;
            r_wr_beats <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rdv <= w_pop;
            if (w_pop) r_rdata <= r_fifo[r_rd_ptr[FIFO_AW-1:0]];
            r_rd_beats <= r_rd_beats + 64'(r_rdv);
            r_wr_beats <= r_wr_beats + 64'(w_commit);
            if (w_err) r_err <= 1'b1;
        end
    end

    assign avs.avs_waitrequest   = w_wait;
    assign avs.avs_readdata      = r_rdata;
    assign avs.avs_readdatavalid = r_rdv;
    assign rd_beats              = r_rd_beats;
    assign wr_beats              = r_wr_beats;
    assign err_sticky            = r_err;
endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: bursts, byte enables, wrap, backpressure, errors, reset.
// Latency: read beats timed against READ_LATENCY+2 cycles after the accepting edge.
// Backpressure: host drives on negedge, samples on negedge, waits on waitrequest with bounded loops.
module tb_avalon_mem_responder;
    localparam int RL = 4;
    localparam int DW = 512;
    localparam int AW = 27;
    localparam int BW = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rd_beats, wr_beats;
    logic        err_sticky;

    always #5 clk = ~clk;

    avalon_mem_responder_if bus ();

    avalon_mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .avs        (bus),
        .rd_beats   (rd_beats),
        .wr_beats   (wr_beats),
        .err_sticky (err_sticky)
    );

    int           n_chk = 0;
    int           n_err = 0;
    logic [DW-1:0] q_dat[$];
    time          q_t[$];
    time          t_acc;
    logic [63:0]  exp_rd = 0;
    logic [63:0]  exp_wr = 0;

    // Capture every returned beat with its sample time.
    always @(negedge clk) begin
        if (bus.avs_readdatavalid === 1'b1) begin
            q_dat.push_back(bus.avs_readdata);
            q_t.push_back($time);
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = '0;
        bus.avs_burstcount = '0;
        bus.avs_writedata  = '0;
        bus.avs_byteenable = '0;
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (bus.avs_waitrequest && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("wait_timeout", DW'(g), '0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d0,
                            input logic [DW/8-1:0] be);
        for (int k = 0; k < n; k++) begin
            bus.avs_write      = 1'b1;
            bus.avs_address    = a;
            bus.avs_burstcount = BW'(n);
            bus.avs_writedata  = d0 + DW'(k);
            bus.avs_byteenable = be;
            wait_ready();
            @(posedge clk);
            @(negedge clk);
        end
        bus.avs_write = 1'b0;
        exp_wr += 64'(n);
        chk("wr_beats", DW'(wr_beats), DW'(exp_wr));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int n);
        int hi;
        q_dat.delete();
        q_t.delete();
        bus.avs_read       = 1'b1;
        bus.avs_address    = a;
        bus.avs_burstcount = BW'(n);
        wait_ready();
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        bus.avs_read = 1'b0;
        hi = 0;
        while (bus.avs_waitrequest && hi < 1000) begin
            hi++;
            @(negedge clk);
        end
        chk("wait_hi_cycles", DW'(hi), DW'(n));
        repeat (RL + 8) @(negedge clk);
        chk("nbeats", DW'(q_dat.size()), DW'(n));
        exp_rd += 64'(n);
        chk("rd_beats", DW'(rd_beats), DW'(exp_rd));
        if (q_t.size() > 0) begin
            chk("first_lat", DW'(q_t[0] - t_acc), DW'((RL + 2) * 10 + 5));
            chk("contiguous", DW'(q_t[q_t.size()-1] - q_t[0]), DW'((q_t.size() - 1) * 10));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        rst_n        = 1'b0;
        bus.avs_read = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait", DW'(bus.avs_waitrequest), DW'(1));
        chk("rst_rdv", DW'(bus.avs_readdatavalid), DW'(0));
        chk("rst_rd_beats", DW'(rd_beats), '0);
        chk("rst_wr_beats", DW'(wr_beats), '0);
        chk("rst_err", DW'(err_sticky), '0);
        bus.avs_read = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        chk("wait_after_rst", DW'(bus.avs_waitrequest), DW'(0));

        // Burst write 1..4 then burst read back.
        do_write(27'h10, 4, DW'(1), '1);
        do_read(27'h10, 4);
        for (int k = 0; k < 4; k++) chk("burst_dat", q_dat[k], DW'(k + 1));

        // Partial byte enable clears only byte 0.
        do_write(27'h20, 1, '1, '1);
        do_write(27'h20, 1, '0, 64'h1);
        do_read(27'h20, 1);
        chk("be_dat", q_dat[0], {{(DW-8){1'b1}}, 8'h00});

        // Address bits above the RAM index are ignored.
        do_read(27'h400010, 1);
        chk("hi_addr_dat", q_dat[0], DW'(1));

        // Read burst wraps from the top RAM word back to 0.
        do_write(27'd1023, 1, DW'('hA1), '1);
        do_write(27'd0, 1, DW'('hA2), '1);
        do_write(27'd1, 1, DW'('hA3), '1);
        do_read(27'd1023, 3);
        chk("wrap_dat0", q_dat[0], DW'('hA1));
        chk("wrap_dat1", q_dat[1], DW'('hA2));
        chk("wrap_dat2", q_dat[2], DW'('hA3));

        // Long burst well beyond the FIFO depth.
        do_write(27'h100, 64, DW'(1000), '1);
        do_read(27'h100, 64);
        for (int k = 0; k < 64; k++) chk("bp_dat", q_dat[k], DW'(1000 + k));

        // Zero-length read: no beats, sticky error.
        chk("err_clear", DW'(err_sticky), '0);
        do_read(27'h10, 0);
        chk("err_set", DW'(err_sticky), DW'(1));

        // Reset in the middle of a burst-8 read.
        q_dat.delete();
        q_t.delete();
        bus.avs_read       = 1'b1;
        bus.avs_address    = 27'h10;
        bus.avs_burstcount = BW'(8);
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        bus.avs_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        repeat (20) @(negedge clk);
        chk("midrst_nbeats", DW'(q_dat.size()), '0);
        chk("midrst_rd_beats", DW'(rd_beats), '0);
        chk("midrst_err", DW'(err_sticky), '0);

        do_write(27'h30, 2, DW'('h55), '1);
        do_read(27'h30, 2);
        chk("post_rst_dat0", q_dat[0], DW'('h55));
        chk("post_rst_dat1", q_dat[1], DW'('h56));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/avalon_mem_responder.md
# avalon_mem_responder

Avalon-MM burst responder backed by on-chip RAM: the memory end of the local-memory bank port that the application top drives as host (read/write/address/writedata/byteenable/burstcount out; readdata/readdatavalid/waitrequest back). It stands in for a DDR bank in simulation and in on-chip-only builds. It accepts burst writes and burst reads, returns read data through a fixed-latency pipeline and a response FIFO, and reports beat counts and protocol errors.

## Interface
- ADDR_WIDTH, 27, word (512-bit line) address width.
- DATA_WIDTH, 512, data bus width; byteenable is DATA_WIDTH/8.
- BURST_WIDTH, 7, burstcount width.
- MEM_DEPTH_LOG2, 10, log2 of RAM words; address bits above it are ignored.
- READ_LATENCY, 4, RAM read pipeline stages (≥1).
- RSP_FIFO_DEPTH, 16, response FIFO entries (power of 2, ≥ READ_LATENCY+2).

- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- avs_read  in  1  read command.
- avs_write  in  1  write beat.
- avs_address  in  ADDR_WIDTH  word address (first beat only).
- avs_burstcount  in  BURST_WIDTH  beats in burst (first beat only).
- avs_writedata  in  DATA_WIDTH  write data.
- avs_byteenable  in  DATA_WIDTH/8  per-byte write enable.
- avs_waitrequest  out  1  stall; a transfer is accepted when read|write is high and waitrequest is low.
- avs_readdata  out  DATA_WIDTH  read data.
- avs_readdatavalid  out  1  readdata valid this cycle.
- rd_beats  out  64  read beats returned since reset.
- wr_beats  out  64  write beats committed since reset.
- err_sticky  out  1  protocol error seen (burstcount 0, read and write together).

## Operation
- Reset (rst_n low at a clk edge): FSM to IDLE, FIFO and pipeline valids flushed, avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, rd_beats=wr_beats=0, err_sticky=0. RAM contents are preserved. A mid-burst reset abandons the burst; no further beats are returned.
- FSM states: IDLE, WR_BURST, RD_ISSUE.
- IDLE: waitrequest=0.
  - Accepted write: commits beat 0 at address[MEM_DEPTH_LOG2-1:0] under byteenable. Latches addr+1 and remaining=burstcount-1. Goes to WR_BURST if remaining>0, else stays in IDLE.
  - Accepted read: latches addr and remaining=burstcount, then goes to RD_ISSUE.
  - read and write both high: the write is taken and err_sticky is set.
  - burstcount==0: command is consumed with no beats; err_sticky is set; FSM stays in IDLE.
- WR_BURST: waitrequest=0.
  - Each accepted write beat commits at the latched address. Address and burstcount on these beats are ignored.
  - Address increments and remaining decrements per beat; FSM returns to IDLE after the last beat.
  - avs_read high here is ignored (held off by the host-visible protocol); err_sticky is set.
- RD_ISSUE: waitrequest=1.
  - Issues one RAM read per cycle while credit>0, where credit = RSP_FIFO_DEPTH − fifo_count − in_flight.
  - Address increments modulo 2^MEM_DEPTH_LOG2 (wraps within the RAM). FSM returns to IDLE after the last issue.
- Pipeline output pushes into the FIFO. The FIFO pops whenever it is non-empty (and not stall-gated); the popped entry drives readdata/readdatavalid from a register.
- Counters are 64-bit and wrap modulo 2^64. wr_beats increments on each committed beat; rd_beats increments on each cycle avs_readdatavalid is high.
- A write committed at edge N is visible to any read issued at edge N+1 or later.

## Timing
- First read beat: avs_readdatavalid is high exactly READ_LATENCY+2 cycles after the accepting edge (no stall macro).
- Later beats follow back-to-back.
- A burst of B beats leaves waitrequest high for B cycles, returning low on the cycle after the final issue.
- Write beats are accepted at 1 per cycle with no added latency.
- readdatavalid is never backpressured. The credit rule guarantees no FIFO overflow; overflow is an assertion failure.

## Configuration
- AVL_RESP_RANDOM_STALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1, loaded at reset) forces waitrequest=1 in IDLE/WR_BURST when lfsr[1:0]==2'b00.
  - The same condition suppresses both the RD_ISSUE issue and the FIFO pop on that cycle.
  - Latency therefore varies; ordering and data are unchanged.
- Undefined: no LFSR, and timing is exactly as stated above.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with read=1 → waitrequest=1, readdatavalid=0, all counters 0. After release, waitrequest=0 the next cycle.
- Write burst 4 at addr 0x10 with data k+1 and full byteenable, then read burst 4 at 0x10 → data 1,2,3,4 starting exactly READ_LATENCY+2 cycles after read accept; wr_beats=4, rd_beats=4.
- Byteenable: write 0xFF..FF at 0x20, then write 0 with byteenable=0x1 → read returns 0xFF..FF00.
- Wrap: read burst 3 at address 2^MEM_DEPTH_LOG2−1 → words at indices 1023, 0, 1.
- Backpressure: read burst 64 with RSP_FIFO_DEPTH=16 → 64 contiguous valid beats, no overflow assertion, waitrequest high until the last issue.
- Errors: burstcount=0 read → no readdatavalid, err_sticky=1. A reset mid-way through a burst-8 read → no beats after reset; a new write/read pair works.
